texture_refill_ctrl: RTL
========================

# texture_refill_ctrl

Line-refill engine that sits directly downstream of the texture cache's miss port. It accepts one line-miss address at a time, issues a single burst read to the external memory/OSPI bus, and assembles the returned beats into a full cache line. It then presents the line to the cache as a one-cycle `miss_resp_valid` pulse. Only one refill is in flight at any time; the cache holds its miss request until the response pulse.

## Interface
- `LINE_BYTES`, 64: cache line size in bytes; power of two, at least `BEAT_BYTES`.
- `BEAT_BYTES`, 4: memory data-bus width in bytes; power of two.
- Derived: `BEATS = LINE_BYTES/BEAT_BYTES`; `OFF = log2(LINE_BYTES)`; `BEAT_BITS = BEAT_BYTES*8`.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `miss_req_valid`  in  1  cache requests a line refill; held high until the response.
- `miss_req_addr`  in  32  miss address; low `OFF` bits are ignored.
- `miss_req_ready`  out  1  high only in IDLE.
- `miss_resp_valid`  out  1  one-cycle pulse; the full line is on `miss_resp_data`.
- `miss_resp_data`  out  `LINE_BYTES*8`  assembled line; beat k occupies bits [k*BEAT_BITS +: BEAT_BITS].
- `mem_req_valid`  out  1  burst read request.
- `mem_req_addr`  out  32  line-aligned burst start address.
- `mem_req_len`  out  8  beats minus one; constant `BEATS-1`.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_rvalid`  in  1  read beat valid; there is no backpressure, so the block must accept every beat.
- `mem_rdata`  in  `BEAT_BITS`  read beat data; beats arrive in ascending address order.
- `busy`  out  1  high in any state other than IDLE.
- `refill_count`  out  16  number of completed refills; wraps modulo 2^16.

## Operation
States and transitions:
- IDLE: `miss_req_ready`=1.
  - On `miss_req_valid`, latch `{miss_req_addr[31:OFF], OFF'b0}` into the address register, clear the beat counter and go to REQ.
- REQ: `mem_req_valid`=1, with `mem_req_addr` held at the latched address.
  - On `mem_req_ready`, go to DATA.
  - The request stays asserted with stable address and length until accepted.
- DATA: each cycle with `mem_rvalid`=1:
  - write `mem_rdata` into line slot `beat_cnt`;
  - increment `beat_cnt`.
  - The beat with `beat_cnt==BEATS-1` completes the line and moves the block to RESP.
  - Gaps in `mem_rvalid` are allowed and simply wait.
- RESP: `miss_resp_valid`=1 for exactly one cycle, then unconditionally go to IDLE. `refill_count` increments on this cycle.

Other rules:
- `mem_rvalid` in IDLE, REQ or RESP is discarded; it does not change the line register or the counter.
- `miss_resp_data` is registered. It holds the last assembled line until the next refill overwrites it slot by slot. Consumers may sample it only during the pulse.
- `miss_req_valid` outside IDLE is ignored; the block never queues a second request.
- `beat_cnt` is `log2(BEATS)`+1 bits wide. It never wraps within a burst because DATA exits at `BEATS-1`.
- `refill_count` wraps 0xFFFF to 0x0000 without any flag.
- Reset, asserted in any state, takes effect on the next edge:
  - state becomes IDLE;
  - `beat_cnt`, the address register, the line register and `refill_count` become 0.
  - An interrupted burst is abandoned. Its remaining beats land in IDLE and are discarded. Draining the memory side after a mid-burst reset is the integrator's responsibility.
- Reset values of outputs:
  - `miss_req_ready`=1, `miss_resp_valid`=0, `miss_resp_data`=0;
  - `mem_req_valid`=0, `mem_req_addr`=0, `mem_req_len`=`BEATS-1`;
  - `busy`=0, `refill_count`=0.

## Timing
- Cycle T: IDLE with `miss_req_valid` set, so the request is accepted.
- T+1: REQ, `mem_req_valid`=1. With `mem_req_ready` already high, the burst is accepted in T+1.
- T+2 onward: DATA. With no gaps, beats arrive T+2..T+1+BEATS; with defaults that is T+2..T+17.
- RESP is the cycle after the last beat: T+2+BEATS at minimum (T+18 with defaults).
- IDLE resumes at T+3+BEATS, and a new request can be accepted in that same cycle. The minimum request-to-request spacing is therefore 3+BEATS cycles.
- The cache drops `miss_req_valid` combinationally during the RESP pulse, so the same miss is never re-accepted.
- All outputs are decoded from state or registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic refill.**
  - Stimulus: `miss_req_addr`=0x0000_1234, `mem_req_ready`=1, beats k = 0xA000_0000+k with no gaps.
  - Required: `mem_req_addr`=0x0000_1200, `mem_req_len`=15; one `miss_resp_valid` pulse at T+18; word k of the line = 0xA000_0000+k; `refill_count`=1.
- **Request backpressure.**
  - Stimulus: hold `mem_req_ready` low for 5 cycles.
  - Required: `mem_req_valid` and `mem_req_addr` stay stable for all 5 cycles; the response is delayed by exactly 5 cycles.
- **Beat gaps and stray beats.**
  - Stimulus: insert a 3-cycle gap between beats 7 and 8; also drive `mem_rvalid` during REQ.
  - Required: the stray beat is ignored; the line is still correct; `miss_resp_valid` is 3 cycles later than in the no-gap case.
- **Reset mid-burst.**
  - Stimulus: assert `rst` after 6 beats, then continue beats 6..15 while in IDLE, then issue a new miss to 0x0000_4000.
  - Required: all outputs return to their reset values; stale beats are discarded; the new refill's data is correct; `refill_count`=1.
- **Back-to-back misses.**
  - Stimulus: a second miss, 0x0000_2040, presented in the cycle IDLE resumes.
  - Required: it is accepted immediately; exactly two pulses; `refill_count`=2.
- **Parameter variant.**
  - Stimulus: `BEAT_BYTES`=8.
  - Required: `mem_req_len`=7; the pulse occurs at T+10.

Source files
------------

// File: rtl/texture_refill_ctrl_if.sv
// Cache-miss and memory-burst signals of the texture line-refill engine.
// The refill engine uses the slave view; the cache/memory side uses master.
interface texture_refill_ctrl_if #(
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 4
);
  localparam int BEAT_BITS = BEAT_BYTES * 8;
  localparam int LINE_BITS = LINE_BYTES * 8;

  // Miss port from the texture cache
  logic                 miss_req_valid;
  logic [31:0]          miss_req_addr;
  logic                 miss_req_ready;
  logic                 miss_resp_valid;
  logic [LINE_BITS-1:0] miss_resp_data;

  // Burst read port towards external memory
  logic                 mem_req_valid;
  logic [31:0]          mem_req_addr;
  logic [7:0]           mem_req_len;
  logic                 mem_req_ready;
  logic                 mem_rvalid;
  logic [BEAT_BITS-1:0] mem_rdata;

  modport slave (
    input  miss_req_valid, miss_req_addr, mem_req_ready, mem_rvalid, mem_rdata,
    output miss_req_ready, miss_resp_valid, miss_resp_data,
           mem_req_valid, mem_req_addr, mem_req_len
  );

  modport master (
    output miss_req_valid, miss_req_addr, mem_req_ready, mem_rvalid, mem_rdata,
    input  miss_req_ready, miss_resp_valid, miss_resp_data,
           mem_req_valid, mem_req_addr, mem_req_len
  );
endinterface

// File: rtl/texture_refill_ctrl.sv
// Texture cache line-refill engine: accepts one line miss, issues a single
// burst read, assembles the returned beats into a line and answers the cache
// with a one-cycle response pulse. One refill in flight at a time.
module texture_refill_ctrl #(
  parameter int LINE_BYTES = 64,
  parameter int BEAT_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  texture_refill_ctrl_if.slave  bus,
  output logic                  busy,
  output logic [15:0]           refill_count
);
  localparam int BEATS     = LINE_BYTES / BEAT_BYTES;
  localparam int OFF       = $clog2(LINE_BYTES);
  localparam int BEAT_BITS = BEAT_BYTES * 8;
  localparam int CNT_W     = $clog2(BEATS) + 1;
  localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e                          r_state;
  state_e                          w_next_state;
  logic [31:0]                     r_addr;
  logic [CNT_W-1:0]                r_beat_cnt;
  logic [BEATS-1:0][BEAT_BITS-1:0] r_line;
  logic [15:0]                     r_refill_count;

  logic w_accept;
  logic w_beat_fire;
  logic w_last_beat;
  logic w_unused_addr;

  logic w_miss_req_ready;
  logic w_miss_resp_valid;
  logic w_mem_req_valid;
  logic w_busy;

  // The line offset bits of the miss address are deliberately dropped.
  assign w_unused_addr = ^bus.miss_req_addr[OFF-1:0];

  assign w_accept    = (r_state == S_IDLE) && bus.miss_req_valid;
  assign w_beat_fire = (r_state == S_DATA) && bus.mem_rvalid;
  assign w_last_beat = (r_beat_cnt == CNT_W'(BEATS - 1));

  // State register
  always_ff @(posedge clk) begin
    // NOTE: registers update with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    // NOTE: default first, so no branch leaves the signal unassigned and
    // no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE: if (bus.miss_req_valid)           w_next_state = S_REQ;
      S_REQ:  if (bus.mem_req_ready)            w_next_state = S_DATA;
      S_DATA: if (bus.mem_rvalid && w_last_beat) w_next_state = S_RESP;
      S_RESP:                                   w_next_state = S_IDLE;
      default:                                  w_next_state = S_IDLE;
    endcase
  end

  // Output decode: everything is a function of state only
  always_comb begin
    w_miss_req_ready  = 1'b0;
    w_miss_resp_valid = 1'b0;
    w_mem_req_valid   = 1'b0;
    w_busy            = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_miss_req_ready = 1'b1;
        w_busy           = 1'b0;
      end
      S_REQ:   w_mem_req_valid   = 1'b1;
      S_DATA:  ;
      S_RESP:  w_miss_resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch the line address, assemble beats, count refills
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr         <= '0;
      r_beat_cnt     <= '0;
      // NOTE: the line register is reset on purpose: the response data must
      // read as zero after reset rather than as uninitialised storage.
      r_line         <= '0;
      r_refill_count <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= {bus.miss_req_addr[31:OFF], {OFF{1'b0}}};
        r_beat_cnt <= '0;
      end
      if (w_beat_fire) begin
        r_line[r_beat_cnt[IDX_W-1:0]] <= bus.mem_rdata;
        r_beat_cnt                    <= r_beat_cnt + CNT_W'(1);
      end
      if (r_state == S_RESP) begin
        r_refill_count <= r_refill_count + 16'd1;
      end
    end
  end

  assign bus.miss_req_ready  = w_miss_req_ready;
  assign bus.miss_resp_valid = w_miss_resp_valid;
  assign bus.miss_resp_data  = r_line;
  assign bus.mem_req_valid   = w_mem_req_valid;
  assign bus.mem_req_addr    = r_addr;
  assign bus.mem_req_len     = 8'(BEATS - 1);
  assign busy                = w_busy;
  assign refill_count        = r_refill_count;
endmodule
